bidir_bus_ctrl: RTL
===================

# bidir_bus_ctrl

Parametrised half-duplex bidirectional bus controller. It owns a WIDTH-bit shared tri-state bus and arbitrates direction between a local transmit stream and a receive path strobed by the remote peer. It inserts programmable dead cycles at every direction change, so the local driver and the peer never overlap. It sits between core logic and the chip's bidirectional pad ring and replaces the unclocked single-bit tri-state and bidirectional cells.

## Interface
Parameters:
- WIDTH, 8, bus and data width in bits (≥1)
- TURN, 2, turnaround dead cycles on each direction change (≥1)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- bus_io  inout  WIDTH  shared bus; driven with dout_q when oe_q=1, otherwise high-Z on every bit
- bus_stb  output  1  registered strobe to peer: bus_io carries a valid local word this cycle
- rx_stb  input  1  peer strobe: bus_io carries a valid remote word this cycle
- tx_data  input  WIDTH  word to transmit
- tx_valid  input  1  transmit request / word valid
- tx_ready  output  1  combinational; 1 only in state DRIVE
- rx_data  output  WIDTH  last received word, registered
- rx_valid  output  1  one-cycle pulse: rx_data updated
- oe  output  1  copy of oe_q, for pad control and observation
- err  output  1  sticky: rx_stb seen outside IDLE, or readback mismatch (see Configuration)

## Operation
- States: IDLE (receive), TURN_OUT, DRIVE, TURN_IN. Turnaround counter is ceil(log2(TURN+1)) bits.
- Reset values: state=IDLE, oe_q=0, dout_q=0, bus_stb=0, rx_data=0, rx_valid=0, err=0, counter=0. Reset mid-transfer releases the bus immediately, asynchronously.
- IDLE:
  - bus high-Z.
  - rx_stb=1 → rx_data<=bus_io, rx_valid=1 next cycle.
  - tx_valid=1 → TURN_OUT, counter<=TURN-1.
  - rx_stb and tx_valid both high: the receive is captured and the state still moves to TURN_OUT.
- TURN_OUT:
  - oe_q=0.
  - Counter decrements each cycle; at 0 → DRIVE and oe_q<=1 on the same edge.
- DRIVE:
  - tx_ready=1.
  - tx_valid&tx_ready → dout_q<=tx_data and bus_stb<=1. Otherwise bus_stb<=0.
  - tx_valid=0 → TURN_IN, oe_q<=0, bus_stb<=0, counter<=TURN-1.
- TURN_IN: bus high-Z; counter at 0 → IDLE.
- rx_stb=1 in any state other than IDLE: err<=1 and the word is dropped (collision). rx_valid stays 0.
- err clears only on rst.
- tx_valid dropped during TURN_OUT: DRIVE is still entered, and then exits on the next cycle with no word sent.

## Timing
- Request-to-ready: tx_valid first sampled high in IDLE at edge E → tx_ready high from edge E+TURN.
- Transmit latency: word accepted at edge K → on bus_io with bus_stb=1 during cycle K..K+1.
- Back-to-back: with tx_valid held high, one word per cycle.
- The last word stays on the bus during the cycle in which tx_valid is seen low; oe_q falls at the end of that cycle.
- Release-to-listen: after oe_q falls, exactly TURN cycles in TURN_IN before IDLE samples rx_stb.
- Receive latency: rx_stb at edge K → rx_valid and rx_data valid in cycle K..K+1.

## Configuration
- BIDIR_READBACK_EN defined:
  - In every cycle with oe_q=1 and bus_stb=1, bus_io is compared with dout_q.
  - Any bit mismatch, including X/Z, sets err. This detects a contending peer or a stuck pad.
- BIDIR_READBACK_EN undefined: no compare logic; err is set only by the collision rule.

## Structure
- Package bidir_pkg:
  - state enum (IDLE, TURN_OUT, DRIVE, TURN_IN)
  - default TURN constant
  - a function returning the counter width for a given TURN
- Sub-module bidir_pad, instantiated once and WIDTH wide:
  - tri-state driver (bus_io = oe ? dout : 'bz)
  - unregistered input path returning bus_io to the controller
- FSM, counter, data registers and err logic live in bidir_bus_ctrl.

## Test plan
- Reset check, WIDTH=8, TURN=2: assert rst while in DRIVE → bus_io all Z, oe=0, tx_ready=0, err=0 within the same cycle.
- Single transmit: tx_valid=1 with tx_data=8'hA5 in IDLE at edge 0 → tx_ready at edge 2; bus_io=8'hA5 with bus_stb=1 in cycle 3; oe=0 after cycle 4; IDLE at edge 6.
- Burst: 4 words 8'h01..8'h04 with tx_valid held high → four consecutive bus_stb cycles with the words in order, no gaps.
- Receive: peer drives 8'h3C with rx_stb=1 in IDLE → rx_data=8'h3C and a one-cycle rx_valid on the next edge.
- Collision: rx_stb=1 during TURN_OUT → err=1 and stays 1; rx_valid stays 0.
- Readback (macro on): peer forces bit 0 low while 8'hFF is driven → err=1 one cycle later. With the macro off, err stays 0.

Source files
------------

// File: rtl/bidir_pkg.sv
// Shared types and helpers for the half-duplex bus controller.
// Holds the direction FSM encoding and turnaround counter sizing.
package bidir_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TURN_OUT = 2'd1,
    DRIVE    = 2'd2,
    TURN_IN  = 2'd3
  } state_e;

  localparam int TURN_DEF = 2;

  function automatic int cnt_w(input int turn);
    return $clog2(turn + 1);
  endfunction

endpackage

// File: rtl/bidir_bus_ctrl_if.sv
// Core-side transmit/receive handshake bundle for bidir_bus_ctrl.
// master = core logic, slave = the bus controller.
interface bidir_bus_ctrl_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );

endinterface

// File: rtl/bidir_pad.sv
// Tri-state pad slice: drives the shared bus when enabled,
// and always returns the resolved bus value unregistered.
module bidir_pad #(
  parameter int WIDTH = 8
) (
  inout  wire  [WIDTH-1:0] pad_io,
  input  logic             oe,
  input  logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] din
);

  // Release every bit to high-Z whenever the output enable is low.
  assign pad_io = oe ? dout : {WIDTH{1'bz}};

  // Unregistered readback of whatever is on the bus.
  assign din = pad_io;

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Half-duplex bidirectional bus controller with turnaround dead cycles.
// Optional macro BIDIR_READBACK_EN adds a drive/readback compare into err.
module bidir_bus_ctrl
  import bidir_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TURN  = TURN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] bus_io,
  output logic             bus_stb,
  input  logic             rx_stb,
  output logic             oe,
  output logic             err,
  bidir_bus_ctrl_if.slave  core
);

  localparam int CW = cnt_w(TURN);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TURN - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             oe_q, oe_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             bus_stb_q, bus_stb_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] bus_in;

  bidir_pad #(
    .WIDTH (WIDTH)
  ) u_pad (
    .pad_io (bus_io),
    .oe     (oe_q),
    .dout   (dout_q),
    .din    (bus_in)
  );

  // State register and all datapath flops; reset releases the bus at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      oe_q       <= 1'b0;
      dout_q     <= '0;
      bus_stb_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      oe_q       <= oe_d;
      dout_q     <= dout_d;
      bus_stb_q  <= bus_stb_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
    end
  end

  // Direction sequencing and turnaround countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (core.tx_valid) begin
          state_d = TURN_OUT;
          cnt_d   = CNT_LOAD;
        end
      end
      TURN_OUT: begin
        if (cnt_q == '0) state_d = DRIVE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DRIVE: begin
        if (!core.tx_valid) begin
          state_d = TURN_IN;
          cnt_d   = CNT_LOAD;
        end
      end
      TURN_IN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Drive enable, transmit word, receive capture and sticky error.
  always_comb begin
    oe_d       = oe_q;
    dout_d     = dout_q;
    bus_stb_d  = 1'b0;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    err_d      = err_q;

    if (rx_stb) begin
      if (state_q == IDLE) begin
        rx_data_d  = bus_in;
        rx_valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (state_q == TURN_OUT && cnt_q == '0) begin
      oe_d = 1'b1;
    end

    if (state_q == DRIVE) begin
      if (core.tx_valid) begin
        dout_d    = core.tx_data;
        bus_stb_d = 1'b1;
      end else begin
        oe_d = 1'b0;
      end
    end

`ifdef BIDIR_READBACK_EN
    // Unknown or floating bits fall to default and count as mismatch.
    if (oe_q && bus_stb_q) begin
      case (bus_in == dout_q)
        1'b1:    ;
        default: err_d = 1'b1;
      endcase
    end
`endif
  end

  assign core.tx_ready = (state_q == DRIVE);
  assign core.rx_data  = rx_data_q;
  assign core.rx_valid = rx_valid_q;
  assign bus_stb       = bus_stb_q;
  assign oe            = oe_q;
  assign err           = err_q;

endmodule
